sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Sequences the shared instruction/data SRAM between two requesters.
  - Instruction fetch (IF): the PC register's fetch port.
  - Data access (MEM): the load/store stage.
- Runs a fixed-length SRAM access FSM and returns a one-cycle ready pulse.
- Raises per-requester stall requests into the pipeline stall controller, so the PC advances only on a completed fetch.
- MEM has fixed priority over IF. A granted access is never pre-empted.

Parameters:
- WAIT_CYCLES, 2, number of cycles SRAM strobes are held active per access (legal 1..15).
- ADDR_W, 20, SRAM word-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- if_ce_n_i  in  1  IF request, active low; held with stable address until if_ready_o.
- if_addr_i  in  32  IF byte address.
- if_rdata_o  out  32  fetched instruction, registered.
- if_ready_o  out  1  one-cycle pulse; if_rdata_o valid.
- mem_ce_n_i  in  1  MEM request, active low; held with stable address and data until mem_ready_o.
- mem_we_n_i  in  1  0 = write, 1 = read.
- mem_addr_i  in  32  MEM byte address.
- mem_wdata_i  in  32  write data.
- mem_be_n_i  in  4  write byte enables, active low.
- mem_rdata_o  out  32  load data, registered.
- mem_ready_o  out  1  one-cycle pulse; access complete.
- stallreq_if_o  out  1  IF pending and not completing this cycle.
- stallreq_mem_o  out  1  MEM pending and not completing this cycle.
- sram_addr_o  out  ADDR_W  word address.
- sram_wdata_o  out  32  write data to pad.
- sram_rdata_i  in  32  read data from pad.
- sram_data_oe_o  out  1  1 = drive pad with sram_wdata_o.
- sram_ce_n_o  out  1  SRAM chip enable, active low.
- sram_oe_n_o  out  1  SRAM output enable, active low.
- sram_we_n_o  out  1  SRAM write enable, active low.
- sram_be_n_o  out  4  SRAM byte enables, active low.

Behaviour:
- FSM states: IDLE, ACCESS, DONE. A 4-bit down-counter counts cycles in ACCESS.
- Reset (rst=0 at an edge, from any state including mid-access):
  - state=IDLE.
  - sram_ce_n_o, sram_oe_n_o, sram_we_n_o = 1; sram_be_n_o=4'hF; sram_data_oe_o=0.
  - sram_addr_o=0; sram_wdata_o=0.
  - Both ready outputs = 0; both rdata outputs = 0; owner cleared.
  - Stall requests follow their combinational definitions.
- IDLE, grant:
  - If mem_ce_n_i=0: grant MEM (wins over a simultaneous IF request).
  - Else if if_ce_n_i=0: grant IF.
  - On grant, at the edge:
    - Latch owner and write flag; IF is always a read.
    - Latch sram_addr_o = addr[ADDR_W+1:2].
    - Latch sram_be_n_o: reads 4'h0; MEM writes mem_be_n_i.
    - Latch sram_wdata_o.
    - Load counter with WAIT_CYCLES-1; go to ACCESS.
  - No request: stay IDLE, strobes inactive.
- ACCESS:
  - sram_ce_n_o=0.
  - Read: sram_oe_n_o=0.
  - Write: sram_we_n_o=0 and sram_data_oe_o=1.
  - Counter decrements each cycle. Total duration is WAIT_CYCLES cycles.
  - At the edge leaving the last ACCESS cycle:
    - Read: capture sram_rdata_i into the owner's rdata register; the other rdata register is unchanged.
    - Go to DONE.
- DONE, exactly one cycle:
  - All strobes inactive.
  - sram_addr_o, sram_be_n_o, sram_wdata_o and sram_data_oe_o are held (write hold time).
  - Owner's ready=1. Next state IDLE.
  - A request still asserted in the following IDLE cycle is a new access.
- Latency: request first seen in IDLE at cycle 0 -> ready at cycle WAIT_CYCLES+1. Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- Stall requests (combinational):
  - stallreq_if_o = ~if_ce_n_i & ~if_ready_o.
  - stallreq_mem_o = ~mem_ce_n_i & ~mem_ready_o.
  - A losing or waiting requester keeps its stall high through the other's whole access.
- Outputs not driven by ready are held; rdata registers keep their last captured value.
- A requester dropping its request mid-access does not abort the access; ready still pulses. The requester must ignore it.

Test Plan:
- Reset mid-write: rst=0 during ACCESS -> next cycle all strobes 1, sram_data_oe_o=0, state IDLE; a subsequent read completes normally.
- IF read, WAIT_CYCLES=2, if_addr_i=32'h80000010:
  - sram_addr_o=20'h00004; ce_n/oe_n low for cycles 1-2.
  - sram_rdata_i=32'h3C011234 captured; if_rdata_o=32'h3C011234 and if_ready_o=1 at cycle 3.
  - stallreq_if_o=1 in cycles 0-2, 0 in cycle 3.
- MEM byte write, addr 32'h80000403, be_n 4'b0111, wdata 32'hAB000000:
  - sram_we_n_o low for 2 cycles; sram_be_n_o=4'b0111.
  - data_oe held through DONE; mem_ready_o=1 at cycle 3.
- Simultaneous IF and MEM requests in IDLE:
  - MEM served first (ready at cycle 3); IF granted at cycle 4, ready at cycle 7.
  - stallreq_if_o=1 throughout cycles 0-6.
- MEM request arriving during IF ACCESS:
  - IF completes uninterrupted; MEM granted in the next IDLE.
  - stallreq_mem_o stays 1 until mem_ready_o.
- Back-to-back fetches of 32'h80000000, 32'h80000004 with WAIT_CYCLES=1: ready pulses at cycles 2 and 5; addresses 0 and 1 on sram_addr_o.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one instruction/data SRAM between the instruction-fetch port (IF)
//   and the load/store port (MEM). MEM has fixed priority; once an access is
//   granted it runs to completion (IDLE -> ACCESS x WAIT_CYCLES -> DONE).
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   if_*                IF request (ce_n, addr) and response (rdata, ready)
//   mem_*               MEM request (ce_n, we_n, addr, wdata, be_n) and
//                       response (rdata, ready)
//   stallreq_if_o/mem_o pending-and-not-completing stall requests
//   sram_*              SRAM pad interface (address, data, strobes)
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce_n_i,
    input  logic [31:0]       if_addr_i,
    output logic [31:0]       if_rdata_o,
    output logic              if_ready_o,
    input  logic              mem_ce_n_i,
    input  logic              mem_we_n_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic [3:0]        mem_be_n_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_ready_o,
    output logic              stallreq_if_o,
    output logic              stallreq_mem_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i,
    output logic              sram_data_oe_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_owner_mem;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be_n;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_mem_rdata;

    logic w_grant_mem;
    logic w_grant_if;
    logic w_last;
    logic w_unused;

    // Only the word-address bits reach the pad; the rest are intentionally dropped.
    assign w_unused = ^{if_addr_i, mem_addr_i};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_mem = (r_state == S_IDLE) && !mem_ce_n_i;
        w_grant_if  = (r_state == S_IDLE) && mem_ce_n_i && !if_ce_n_i;
        w_last      = (r_state == S_ACCESS) && (r_cnt == 4'd0);
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_grant_mem || w_grant_if) w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_last) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // Access context: latched on grant, held through DONE and beyond
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= 4'd0;
            r_owner_mem <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_be_n      <= 4'hF;
            r_if_rdata  <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else begin
            if (w_grant_mem || w_grant_if) begin
                r_owner_mem <= w_grant_mem;
                r_we        <= w_grant_mem && !mem_we_n_i;
                r_addr      <= w_grant_mem ? mem_addr_i[ADDR_W+1:2]
                                           : if_addr_i[ADDR_W+1:2];
                r_be_n      <= (w_grant_mem && !mem_we_n_i) ? mem_be_n_i : 4'h0;
                r_wdata     <= mem_wdata_i;
                r_cnt       <= CNT_INIT;
            end else if (r_state == S_ACCESS && !w_last) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Read data is sampled on the edge closing the last strobe cycle.
            if (w_last && !r_we) begin
                if (r_owner_mem) r_mem_rdata <= sram_rdata_i;
                else             r_if_rdata  <= sram_rdata_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        sram_ce_n_o    = 1'b1;
        sram_oe_n_o    = 1'b1;
        sram_we_n_o    = 1'b1;
        sram_data_oe_o = 1'b0;
        if_ready_o     = 1'b0;
        mem_ready_o    = 1'b0;
        if (r_state == S_ACCESS) begin
            sram_ce_n_o = 1'b0;
            sram_oe_n_o = r_we;
            sram_we_n_o = !r_we;
        end
        // Pad drive stays on during DONE to give the write data hold time.
        if (r_state == S_ACCESS || r_state == S_DONE) sram_data_oe_o = r_we;
        if (r_state == S_DONE) begin
            if_ready_o  = !r_owner_mem;
            mem_ready_o = r_owner_mem;
        end
    end

    assign sram_addr_o    = r_addr;
    assign sram_wdata_o   = r_wdata;
    assign sram_be_n_o    = r_be_n;
    assign if_rdata_o     = r_if_rdata;
    assign mem_rdata_o    = r_mem_rdata;
    assign stallreq_if_o  = !if_ce_n_i && !if_ready_o;
    assign stallreq_mem_o = !mem_ce_n_i && !mem_ready_o;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed and randomized bench for sram_arbiter. A transaction timeline
//   model (grant cycle + age of the access) predicts every output each cycle.
module tb_sram_arbiter;

    localparam int W  = 2;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_ce_n_i = 1'b1;
    logic [31:0]   if_addr_i = 32'd0;
    logic [31:0]   if_rdata_o;
    logic          if_ready_o;
    logic          mem_ce_n_i = 1'b1;
    logic          mem_we_n_i = 1'b1;
    logic [31:0]   mem_addr_i = 32'd0;
    logic [31:0]   mem_wdata_i = 32'd0;
    logic [3:0]    mem_be_n_i = 4'hF;
    logic [31:0]   mem_rdata_o;
    logic          mem_ready_o;
    logic          stallreq_if_o;
    logic          stallreq_mem_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_wdata_o;
    logic [31:0]   sram_rdata_i = 32'd0;
    logic          sram_data_oe_o;
    logic          sram_ce_n_o;
    logic          sram_oe_n_o;
    logic          sram_we_n_o;
    logic [3:0]    sram_be_n_o;

    sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .if_ce_n_i(if_ce_n_i), .if_addr_i(if_addr_i),
        .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
        .mem_ce_n_i(mem_ce_n_i), .mem_we_n_i(mem_we_n_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_be_n_i(mem_be_n_i), .mem_rdata_o(mem_rdata_o),
        .mem_ready_o(mem_ready_o),
        .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
        .sram_rdata_i(sram_rdata_i), .sram_data_oe_o(sram_data_oe_o),
        .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
        .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: an access is "active" from its grant edge; its age
    // counts cycles since the grant cycle. Ages 1..W strobe, age W+1 is DONE.
    bit          act = 1'b0;
    int          age = 0;
    bit          own_mem = 1'b0;
    bit          own_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [31:0] e_wdata = 32'd0;
    logic [3:0]  e_be = 4'hF;
    logic [31:0] e_ifr = 32'd0;
    logic [31:0] e_memr = 32'd0;
    bit          last_if_rdy = 1'b0;
    bit          last_mem_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        act = 1'b0; age = 0; own_mem = 1'b0; own_we = 1'b0;
        e_addr = '0; e_wdata = 32'd0; e_be = 4'hF; e_ifr = 32'd0; e_memr = 32'd0;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model on the edge.
    task automatic step();
        bit acc, dn, eif, emem;
        @(negedge clk);
        acc  = act && (age >= 1) && (age <= W);
        dn   = act && (age == W + 1);
        eif  = dn && !own_mem;
        emem = dn && own_mem;
        chk("ce_n",      32'(sram_ce_n_o),    32'(!acc));
        chk("oe_n",      32'(sram_oe_n_o),    32'(!(acc && !own_we)));
        chk("we_n",      32'(sram_we_n_o),    32'(!(acc && own_we)));
        chk("data_oe",   32'(sram_data_oe_o), 32'((acc || dn) && own_we));
        chk("addr",      32'(sram_addr_o),    32'(e_addr));
        chk("wdata",     sram_wdata_o,        e_wdata);
        chk("be_n",      32'(sram_be_n_o),    32'(e_be));
        chk("if_ready",  32'(if_ready_o),     32'(eif));
        chk("mem_ready", 32'(mem_ready_o),    32'(emem));
        chk("if_rdata",  if_rdata_o,          e_ifr);
        chk("mem_rdata", mem_rdata_o,         e_memr);
        chk("stall_if",  32'(stallreq_if_o),  32'(!if_ce_n_i && !eif));
        chk("stall_mem", 32'(stallreq_mem_o), 32'(!mem_ce_n_i && !emem));
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (act) begin
            if (age == W && !own_we) begin
                if (own_mem) e_memr = sram_rdata_i;
                else         e_ifr  = sram_rdata_i;
            end
            if (dn) act = 1'b0;
            else    age++;
        end else if (!mem_ce_n_i || !if_ce_n_i) begin
            act     = 1'b1;
            age     = 1;
            own_mem = !mem_ce_n_i;
            own_we  = !mem_ce_n_i && !mem_we_n_i;
            e_addr  = !mem_ce_n_i ? mem_addr_i[AW+1:2] : if_addr_i[AW+1:2];
            e_be    = own_we ? mem_be_n_i : 4'h0;
            e_wdata = mem_wdata_i;
        end
        last_if_rdy  = eif;
        last_mem_rdy = emem;
        #1;
    endtask

    // Run until both requesters have been served and the arbiter is idle;
    // each requester releases its request right after its ready pulse.
    task automatic run_until_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!(mem_ce_n_i && if_ce_n_i && !act) && n < max_cycles) begin
            step();
            if (last_mem_rdy) mem_ce_n_i = 1'b1;
            if (last_if_rdy)  if_ce_n_i  = 1'b1;
            n++;
        end
        total++;
        assert (n < max_cycles) else begin
            bad++;
            $error("FAIL %s_timeout observed=%0d expected<%0d", tag, n, max_cycles);
        end
    endtask

    initial begin
        // Reset from an unknown start, then check the reset state.
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        step();
        rst = 1'b1;
        step();

        // IF read of 0x80000010.
        sram_rdata_i = 32'h3C011234;
        if_addr_i    = 32'h80000010;
        if_ce_n_i    = 1'b0;
        run_until_idle("if_read", 20);
        chk("if_read_addr",  32'(sram_addr_o), 32'h00004);
        chk("if_read_rdata", if_rdata_o,       32'h3C011234);
        step();

        // MEM byte write.
        mem_addr_i  = 32'h80000403;
        mem_be_n_i  = 4'b0111;
        mem_wdata_i = 32'hAB000000;
        mem_we_n_i  = 1'b0;
        mem_ce_n_i  = 1'b0;
        run_until_idle("mem_write", 20);
        chk("mem_write_be",    32'(sram_be_n_o), 32'h7);
        chk("mem_write_wdata", sram_wdata_o,     32'hAB000000);
        chk("mem_write_addr",  32'(sram_addr_o), 32'h00100);

        // Simultaneous IF and MEM read: MEM goes first.
        sram_rdata_i = 32'h11223344;
        mem_we_n_i   = 1'b1;
        mem_addr_i   = 32'h80000020;
        mem_ce_n_i   = 1'b0;
        if_addr_i    = 32'h80000024;
        if_ce_n_i    = 1'b0;
        run_until_idle("simul", 30);
        chk("simul_mem_rdata", mem_rdata_o, 32'h11223344);

        // MEM request arriving while IF is mid-access.
        sram_rdata_i = 32'h55667788;
        if_addr_i    = 32'h80000100;
        if_ce_n_i    = 1'b0;
        step();
        step();
        mem_addr_i = 32'h80000200;
        mem_ce_n_i = 1'b0;
        run_until_idle("mem_during_if", 30);

        // Back-to-back fetches of consecutive words.
        sram_rdata_i = 32'h0000AAAA;
        if_addr_i    = 32'h80000000;
        if_ce_n_i    = 1'b0;
        for (int i = 0; i < 20 && !last_if_rdy; i++) step();
        chk("b2b_first_ready", 32'(last_if_rdy), 32'd1);
        if_addr_i    = 32'h80000004;
        sram_rdata_i = 32'h0000BBBB;
        run_until_idle("b2b", 20);
        chk("b2b_addr",  32'(sram_addr_o), 32'h00001);
        chk("b2b_rdata", if_rdata_o,       32'h0000BBBB);

        // Reset in the middle of a write, then a normal read.
        mem_addr_i  = 32'h80000808;
        mem_we_n_i  = 1'b0;
        mem_be_n_i  = 4'h0;
        mem_wdata_i = 32'hDEADBEEF;
        mem_ce_n_i  = 1'b0;
        step();
        step();
        rst        = 1'b0;
        mem_ce_n_i = 1'b1;
        step();
        rst = 1'b1;
        step();
        mem_we_n_i   = 1'b1;
        mem_addr_i   = 32'h8000000C;
        sram_rdata_i = 32'hCAFEF00D;
        mem_ce_n_i   = 1'b0;
        run_until_idle("after_reset_read", 20);
        chk("after_reset_rdata", mem_rdata_o, 32'hCAFEF00D);

        // Randomized traffic obeying the hold-until-ready protocol.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
            sram_rdata_i = $urandom;
            if (if_ce_n_i || last_if_rdy) begin
                if ($urandom_range(0, 2) == 0) begin
                    if_ce_n_i = 1'b0;
                    if_addr_i = {12'h800, 18'($urandom), 2'b00};
                end else begin
                    if_ce_n_i = 1'b1;
                end
            end
            if (mem_ce_n_i || last_mem_rdy) begin
                if ($urandom_range(0, 2) == 0) begin
                    mem_ce_n_i  = 1'b0;
                    mem_we_n_i  = 1'($urandom);
                    mem_addr_i  = $urandom;
                    mem_wdata_i = $urandom;
                    mem_be_n_i  = 4'($urandom);
                end else begin
                    mem_ce_n_i = 1'b1;
                end
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
